// File: rtl/fifo_stream_adapter.sv
// Read-side adapter: drains a 1-cycle-latency synchronous FIFO into a burst-framed valid/ready stream.
// Define FIFO_ADAPT_CKSUM_EN to append an XOR checksum beat after every burst of BURST_LEN data beats.
module fifo_stream_adapter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_dout_i,
    output logic              fifo_read_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic [7:0]        burst_cnt_o
);

    localparam int unsigned       WCNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BURST_LEN - 1);

    logic [DATA_W-1:0] buf_q [2];
    logic [DATA_W-1:0] buf_d [2];
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;

    logic              in_data;
    logic              pop;
    logic              last_data;
    logic              burst_done;
    logic              wr_idx;
    logic [2:0]        level;

    assign pop       = in_data && (occ_q != 2'd0) && m_ready_i;
    assign last_data = (wcnt_q == WCNT_LAST);

    // Words held after this cycle: buffered + returning - leaving; read only if it stays below 2.
    assign level       = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    assign fifo_read_o = rst_ni && !fifo_empty_i && (level < 3'd2);

    // Returning word lands behind whatever survives this cycle's pop.
    assign wr_idx = pop ? (occ_q == 2'd2) : (occ_q == 2'd1);

`ifdef FIFO_ADAPT_CKSUM_EN
    typedef enum logic {
        ST_DATA  = 1'b0,
        ST_CKSUM = 1'b1
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] cksum_q;

    assign in_data    = (state_q == ST_DATA);
    assign m_valid_o  = in_data ? (occ_q != 2'd0) : 1'b1;
    assign m_data_o   = in_data ? buf_q[0] : cksum_q;
    assign m_last_o   = !in_data;
    assign burst_done = !in_data && m_ready_i;

    // Burst framing FSM with running XOR of accepted data words.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_DATA;
            cksum_q <= '0;
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (pop) begin
                        cksum_q <= cksum_q ^ buf_q[0];
                        if (last_data) begin
                            state_q <= ST_CKSUM;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (m_ready_i) begin
                        cksum_q <= '0;
                        state_q <= ST_DATA;
                    end
                end
            endcase
        end
    end
`else
    assign in_data    = 1'b1;
    assign m_valid_o  = (occ_q != 2'd0);
    assign m_data_o   = buf_q[0];
    assign m_last_o   = m_valid_o && last_data;
    assign burst_done = pop && last_data;
`endif

    always_comb begin
        buf_d       = buf_q;
        occ_d       = 2'(level);
        wcnt_d      = wcnt_q;
        burst_cnt_d = burst_cnt_q;
        if (pop) begin
            buf_d[0] = buf_q[1];
            wcnt_d   = last_data ? '0 : wcnt_q + WCNT_W'(1);
        end
        if (inflight_q) begin
            buf_d[wr_idx] = fifo_dout_i;
        end
        if (burst_done) begin
            burst_cnt_d = burst_cnt_q + 8'd1;
        end
    end

    // A word in flight at reset is dropped by clearing inflight_q.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            occ_q       <= '0;
            inflight_q  <= 1'b0;
            wcnt_q      <= '0;
            burst_cnt_q <= '0;
        end else begin
            buf_q       <= buf_d;
            occ_q       <= occ_d;
            inflight_q  <= fifo_read_o;
            wcnt_q      <= wcnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign burst_cnt_o = burst_cnt_q;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: FIFO model, burst/checksum reference queue, directed and random traffic.
`timescale 1ns/1ps
module tb_fifo_stream_adapter;

    localparam int unsigned BL = 8;
`ifdef FIFO_ADAPT_CKSUM_EN
    localparam bit CKSUM = 1'b1;
`else
    localparam bit CKSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_read;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic [7:0]  burst_cnt;

    always #5 clk = ~clk;

    fifo_stream_adapter #(.DATA_W(32), .BURST_LEN(BL)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .fifo_empty_i(fifo_empty),
        .fifo_dout_i (fifo_dout),
        .fifo_read_o (fifo_read),
        .m_valid_o   (m_valid),
        .m_ready_i   (m_ready),
        .m_data_o    (m_data),
        .m_last_o    (m_last),
        .burst_cnt_o (burst_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        e_read;
        logic        e_valid;
        logic        e_last;
        logic [31:0] e_data;
        logic [7:0]  e_bcnt;
    } vec_t;

    beat_t       exp_q[$];
    logic [31:0] fmem [0:4095];
    int unsigned wr_idx = 0, rd_idx = 0;
    bit          hold = 1'b0;
    int          n_cmp = 0, n_err = 0;
    int          exp_bursts = 0;
    int unsigned pos = 0;
    logic [31:0] xacc = '0;
    int          held = 0, accepts = 0, cyc = 0;
    int          first_beat = -1, last_beat = -1;
    logic        s_read, s_valid, s_last;
    logic [31:0] s_data;
    logic [7:0]  s_bcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic update_empty();
        fifo_empty = hold || (rd_idx == wr_idx);
    endtask

    // Reference framing: each word gets its burst position; checksum beats are queued after BL words.
    task automatic push_word(input logic [31:0] w);
        beat_t b;
        fmem[wr_idx % 4096] = w;
        wr_idx++;
        b.data = w;
        b.last = !CKSUM && (pos == BL - 1);
        exp_q.push_back(b);
        xacc ^= w;
        pos++;
        if (pos == BL) begin
            pos = 0;
            if (CKSUM) begin
                b.data = xacc;
                b.last = 1'b1;
                exp_q.push_back(b);
            end
            xacc = '0;
        end
        update_empty();
    endtask

    task automatic step();
        bit    rd;
        bit    hs;
        beat_t e;
        @(negedge clk);
        s_read  = fifo_read;
        s_valid = m_valid;
        s_data  = m_data;
        s_last  = m_last;
        s_bcnt  = burst_cnt;
        rd = rst_n && fifo_read;
        hs = rst_n && m_valid && m_ready;
        if (fifo_read) check("read_while_empty", 32'(fifo_empty), 32'd0);
        check("held_le_2", 32'(held > 2), 32'd0);
        if (rst_n) check("burst_cnt", 32'(burst_cnt), 32'(exp_bursts % 256));
        if (hs) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_unexpected: got 0x%0h, expected no beat (cycle %0d)", m_data, cyc);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", m_data, e.data);
                check("beat_last", 32'(m_last), 32'(e.last));
                if (e.last) exp_bursts++;
            end
            accepts++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
        end
        @(posedge clk);
        #1;
        if (rd) begin
            fifo_dout = fmem[rd_idx % 4096];
            rd_idx++;
        end
        held = held + (rd ? 1 : 0) - (hs ? 1 : 0);
        update_empty();
        cyc++;
    endtask

    task automatic do_reset(input int unsigned ncyc);
        rst_n = 1'b0;
        repeat (ncyc) step();
        exp_q.delete();
        pos        = 0;
        xacc       = '0;
        exp_bursts = 0;
        held       = 0;
        rst_n      = 1'b1;
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        m_ready = 1'b1;
        hold    = 1'b0;
        update_empty();
        while ((exp_q.size() != 0 || rd_idx != wr_idx) && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() != 0 || rd_idx != wr_idx) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: %0d beats pending, expected 0", exp_q.size());
        end
    endtask

    vec_t tbl[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc0;
        int unsigned n;

        tbl[0] = '{rst:1'b0, rdy:1'b1, e_read:1'b0, e_valid:1'b0, e_last:1'b0, e_data:32'h0, e_bcnt:8'd0};
        tbl[1] = '{rst:1'b0, rdy:1'b1, e_read:1'b0, e_valid:1'b0, e_last:1'b0, e_data:32'h0, e_bcnt:8'd0};
        tbl[2] = '{rst:1'b1, rdy:1'b1, e_read:1'b1, e_valid:1'b0, e_last:1'b0, e_data:32'h0, e_bcnt:8'd0};
        tbl[3] = '{rst:1'b1, rdy:1'b1, e_read:1'b1, e_valid:1'b0, e_last:1'b0, e_data:32'h0, e_bcnt:8'd0};
        tbl[4] = '{rst:1'b1, rdy:1'b1, e_read:1'b1, e_valid:1'b1, e_last:1'b0, e_data:32'h1, e_bcnt:8'd0};
        tbl[5] = '{rst:1'b1, rdy:1'b1, e_read:1'b1, e_valid:1'b1, e_last:1'b0, e_data:32'h2, e_bcnt:8'd0};

        rst_n     = 1'b0;
        m_ready   = 1'b1;
        fifo_dout = '0;
        update_empty();

        // Reset with a non-empty FIFO, then stream 16 words 0x1..0x10.
        for (int i = 1; i <= 16; i++) push_word(32'(i));
        for (int i = 0; i < 6; i++) begin
            rst_n   = tbl[i].rst;
            m_ready = tbl[i].rdy;
            step();
            check($sformatf("tbl%0d_read", i), 32'(s_read), 32'(tbl[i].e_read));
            check($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
            check($sformatf("tbl%0d_last", i), 32'(s_last), 32'(tbl[i].e_last));
            check($sformatf("tbl%0d_bcnt", i), 32'(s_bcnt), 32'(tbl[i].e_bcnt));
            if (tbl[i].e_valid) check($sformatf("tbl%0d_data", i), s_data, tbl[i].e_data);
        end
        drain(100);
        step();
        check("stream_span", 32'(last_beat - first_beat + 1), 32'(CKSUM ? 18 : 16));
        check("stream_bcnt", 32'(s_bcnt), 32'd2);

        // Backpressure: 10 stalled cycles mid-stream.
        do_reset(2);
        for (int i = 0; i < 12; i++) push_word(32'hA000_0000 + 32'(i));
        m_ready = 1'b1;
        repeat (6) step();
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_read_low", 32'(s_read), 32'd0);
        end
        check("bp_held", 32'(held), 32'd2);
        drain(100);

        // Empty gap after 3 words, refill later.
        do_reset(2);
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) push_word(32'hB000_0000 + 32'(i));
        repeat (8) step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("gap_valid", 32'(s_valid), 32'd0);
        end
        for (int i = 3; i < 16; i++) push_word(32'hB000_0000 + 32'(i));
        drain(100);

        // Reset after 5 accepted beats abandons the partial burst.
        do_reset(2);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_word(32'hC000_0000 + 32'(i));
        acc0 = accepts;
        n    = 0;
        while (accepts - acc0 < 5 && n < 30) begin
            step();
            n++;
        end
        check("pre_reset_beats", 32'(accepts - acc0), 32'd5);
        do_reset(2);
        for (int i = 0; i < 8; i++) push_word(32'hD000_0000 + 32'(i));
        drain(100);
        step();
        check("post_reset_bcnt", 32'(s_bcnt), 32'(CKSUM ? 1 : 1));

        // Random traffic against the reference queue.
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            if ((wr_idx - rd_idx) < 32 && $urandom_range(0, 1) == 1) push_word($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            hold    = ($urandom_range(0, 7) == 0);
            update_empty();
            step();
        end
        drain(300);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_stream_adapter.md
# fifo_stream_adapter

Drains the 32-bit synchronous FIFO on its read side and presents the words as a valid/ready stream framed into fixed-length bursts. It sits directly downstream of the FIFO: it drives the FIFO's READ, consumes DOUT and EMPTY, and absorbs the FIFO's one-cycle read latency with a 2-entry skid buffer. It sustains one word per cycle while the sink accepts.

## Interface
- DATA_W, 32, word width; matches the FIFO DOUT width.
- BURST_LEN, 8, data words per burst; legal range 1..256.

- CLK  in  1  single clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- FIFO_EMPTY  in  1  FIFO empty flag.
- FIFO_DOUT  in  DATA_W  FIFO read data; valid the cycle after an accepted READ.
- FIFO_READ  out  1  read strobe to the FIFO.
- M_VALID  out  1  output beat valid.
- M_READY  in  1  sink accepts the beat.
- M_DATA  out  DATA_W  output beat data.
- M_LAST  out  1  last beat of a burst.
- BURST_CNT  out  8  completed bursts, modulo 256.

## Operation
- Skid buffer: 2 entries, FIFO order. `occ` is 0..2. `inflight` is 1 when FIFO_READ was high with FIFO_EMPTY low in the previous cycle.
- FIFO_READ is combinational and equals `!FIFO_EMPTY && (occ + inflight - pop) < 2`, where `pop = M_VALID && M_READY` on a data beat.
  - The FIFO is never read while empty.
  - The buffer never overflows.
- Returning word: when `inflight` is 1, FIFO_DOUT is written into the buffer at the end of that cycle.
- Output: M_VALID is high when `occ > 0` in DATA state, and unconditionally in CKSUM state. M_DATA and M_VALID hold stable until accepted.
- Word counter: `wcnt` is clog2(BURST_LEN) bits wide and increments on each accepted data beat.
  - On the BURST_LEN-th beat, M_LAST is high (with no checksum), `wcnt` wraps to 0 and BURST_CNT increments.
  - BURST_CNT wraps 255 -> 0.
- FSM:
  - DATA: default state.
  - DATA -> CKSUM: only with checksum compiled in, after the last data beat of a burst is accepted.
  - CKSUM -> DATA: when the checksum beat is accepted.
- Buffer fill during CKSUM: reads continue while the buffer has room. Data beats are not popped during CKSUM.
- Reset: every output is 0. `occ`, `inflight`, `wcnt`, checksum and BURST_CNT are 0 and the FSM is in DATA. A word in flight at reset is discarded.
- Reset mid-burst: the partial burst is abandoned and no M_LAST is emitted for it. The next word starts a new burst.

## Timing
- Read latency: FIFO_EMPTY falls in cycle 0 -> FIFO_READ high in cycle 0 -> word captured at the end of cycle 1 -> M_VALID high in cycle 2.
- Throughput: with M_READY held high, the block sustains 1 beat per cycle (steady state `occ=1`, `inflight=1`).
- Backpressure: M_READY low for N cycles -> FIFO_READ falls within 1 cycle, and at most 2 words are held.
- Simultaneous capture and pop: both take effect in the same cycle and `occ` is unchanged.
- FIFO going empty mid-burst: M_VALID drops after the buffer drains, and the burst resumes when data returns with `wcnt` preserved.

## Configuration
- FIFO_ADAPT_CKSUM_EN defined:
  - Keeps a running XOR of the data words accepted in the current burst.
  - After BURST_LEN data beats, emits one extra beat with M_DATA equal to that XOR and M_LAST high.
  - The data beats carry M_LAST low.
  - The XOR clears after the checksum beat is accepted.
  - BURST_CNT increments on the checksum beat.
- FIFO_ADAPT_CKSUM_EN undefined:
  - No CKSUM state and no XOR register.
  - M_LAST marks the BURST_LEN-th data beat.

## Test plan
- Reset: hold RESET low for 2 cycles with FIFO_EMPTY low -> FIFO_READ=0, M_VALID=0, M_LAST=0, BURST_CNT=0. FIFO_READ rises in the first cycle after RESET goes high.
- Streaming: FIFO holds 16 words 0x1..0x10, M_READY=1, BURST_LEN=8, no checksum -> 16 consecutive beats 0x1..0x10 starting 2 cycles after the first READ. M_LAST is high on 0x8 and 0x10, and BURST_CNT reads 2.
- Checksum build: define FIFO_ADAPT_CKSUM_EN, 8 words 0x1..0x8 -> 9 beats. The 9th beat is 0x8 with M_LAST high, which is the XOR of 0x1..0x8.
- Backpressure: M_READY is low for 10 cycles mid-stream -> FIFO_READ=0 after at most 2 buffered words. No word is lost or duplicated, and order is preserved.
- Empty gap: the FIFO empties after 3 words and refills 5 cycles later -> M_VALID low during the gap. M_LAST lands on the 8th word overall.
- Reset mid-burst: assert RESET after 5 accepted beats, then stream 8 words -> no M_LAST before reset. M_LAST is on the 8th word after reset, and BURST_CNT=1.
